fir_transposed_segment: RTL

- Parametrised transposed-form FIR tap segment with N_TAPS taps, configurable data, coefficient and accumulator widths.
- Cascadable: upstream segment's partial sum enters on iCascIn; full-precision partial sum leaves on oCascOut for the next segment.
- Adds double-buffered coefficient loading with sample-aligned commit, round/saturate output stage, pipeline-fill valid and a sticky saturation flag.
- Sits in the filter datapath at the 12 MHz clock, advanced by the sample strobe.

---
 rtl/fir_pkg.sv | 33 +++
 rtl/fir_round_sat.sv | 43 ++++
 rtl/fir_transposed_segment.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared FIR definitions: default widths, rounding modes and saturation limit helpers.
package fir_pkg;

  localparam int unsigned FIR_N_TAPS = 3;
  localparam int unsigned FIR_DATA_W = 3;
  localparam int unsigned FIR_COEF_W = 16;
  localparam int unsigned FIR_ACC_W  = 24;
  localparam int unsigned FIR_OUT_W  = 16;
  localparam int unsigned FIR_SHIFT  = 0;

  typedef enum logic {
    RND_TRUNC   = 1'b0,
    RND_HALF_UP = 1'b1
  } rnd_mode_e;

  function automatic rnd_mode_e rnd_mode(input int unsigned shift);
    return (shift > 0) ? RND_HALF_UP : RND_TRUNC;
  endfunction

  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Limits of a w-bit signed value, returned in 64 bits for the caller to narrow.
  function automatic logic signed [63:0] sat_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational round-half-up (optional) and saturate from ACC_W to OUT_W with clip flag.
module fir_round_sat
  import fir_pkg::*;
#(
  parameter int unsigned ACC_W = FIR_ACC_W,
  parameter int unsigned OUT_W = FIR_OUT_W,
  parameter int unsigned SHIFT = FIR_SHIFT
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [OUT_W-1:0] res,
  output logic                    clip
);

  localparam rnd_mode_e MODE = rnd_mode(SHIFT);
  localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'(sat_max(OUT_W));
  localparam logic signed [ACC_W:0] MINV = (ACC_W+1)'(sat_min(OUT_W));

  logic signed [ACC_W:0] ext;
  logic signed [ACC_W:0] rnd;

  // One guard bit keeps the rounding bias from overflowing the accumulator range.
  assign ext = {acc[ACC_W-1], acc};

  if (MODE == RND_HALF_UP) begin : g_round
    localparam logic signed [ACC_W:0] BIAS = (ACC_W+1)'(1) <<< (SHIFT - 1);
    assign rnd = (ext + BIAS) >>> SHIFT;
  end else begin : g_pass
    assign rnd = ext;
  end

  always_comb begin
    res  = rnd[OUT_W-1:0];
    clip = 1'b0;
    if (rnd > MAXV) begin
      res  = MAXV[OUT_W-1:0];
      clip = 1'b1;
    end else if (rnd < MINV) begin
      res  = MINV[OUT_W-1:0];
      clip = 1'b1;
    end
  end

endmodule

// File: rtl/fir_transposed_segment.sv
// Cascadable transposed-form FIR tap segment with double-buffered coefficients,
// sample-aligned commit, round/saturate output, pipeline-fill valid and sticky clip flag.
module fir_transposed_segment
  import fir_pkg::*;
#(
  parameter int unsigned N_TAPS = FIR_N_TAPS,
  parameter int unsigned DATA_W = FIR_DATA_W,
  parameter int unsigned COEF_W = FIR_COEF_W,
  parameter int unsigned ACC_W  = FIR_ACC_W,
  parameter int unsigned OUT_W  = FIR_OUT_W,
  parameter int unsigned SHIFT  = FIR_SHIFT
) (
  input  logic                          iClk_12M,
  input  logic                          iRst,
  input  logic                          iEnSample,
  input  logic signed [DATA_W-1:0]      iFirIn,
  input  logic signed [ACC_W-1:0]       iCascIn,
  input  logic                          iCoeffWrEn,
  input  logic [addr_w(N_TAPS)-1:0]     iCoeffAddr,
  input  logic signed [COEF_W-1:0]      iCoeffData,
  input  logic                          iCoeffCommit,
  input  logic                          iClrFlag,
  output logic signed [ACC_W-1:0]       oCascOut,
  output logic signed [OUT_W-1:0]       oFirOut,
  output logic                          oValid,
  output logic                          oCommitPending,
  output logic                          oSatFlag
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned CNT_W  = $clog2(N_TAPS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_TAPS + 1);

  logic signed [COEF_W-1:0] c_act    [N_TAPS];
  logic signed [COEF_W-1:0] c_shd    [N_TAPS];
  logic signed [ACC_W-1:0]  r_s      [N_TAPS];
  logic signed [ACC_W-1:0]  prod_ext [N_TAPS];
  logic signed [PROD_W-1:0] prod;
  logic signed [OUT_W-1:0]  rs_out;
  logic signed [OUT_W-1:0]  fir_out_r;
  logic [CNT_W-1:0]         fill_cnt;
  logic [CNT_W-1:0]         fill_nxt;
  logic                     clip;
  logic                     addr_ok;
  logic                     commit_pend;
  logic                     valid_r;
  logic                     sat_flag;

  always_comb begin
    prod = '0;
    for (int unsigned k = 0; k < N_TAPS; k++) begin
      prod        = iFirIn * c_act[k];
      prod_ext[k] = ACC_W'(prod);
    end
  end

  assign addr_ok  = 32'(iCoeffAddr) < N_TAPS;
  assign fill_nxt = (fill_cnt == CNT_FULL) ? fill_cnt : fill_cnt + 1'b1;

  fir_round_sat #(
    .ACC_W(ACC_W),
    .OUT_W(OUT_W),
    .SHIFT(SHIFT)
  ) u_round_sat (
    .acc (r_s[N_TAPS-1]),
    .res (rs_out),
    .clip(clip)
  );

  always_ff @(posedge iClk_12M) begin
    if (iRst) begin
      for (int unsigned k = 0; k < N_TAPS; k++) begin
        r_s[k]   <= '0;
        c_act[k] <= '0;
        c_shd[k] <= '0;
      end
      fir_out_r   <= '0;
      fill_cnt    <= '0;
      valid_r     <= 1'b0;
      commit_pend <= 1'b0;
      sat_flag    <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      if (iCoeffWrEn && addr_ok)
        c_shd[iCoeffAddr] <= iCoeffData;

      if (iEnSample) begin
        r_s[0] <= iCascIn + prod_ext[0];
        for (int unsigned k = 1; k < N_TAPS; k++)
          r_s[k] <= r_s[k-1] + prod_ext[k];
        fir_out_r <= rs_out;
        fill_cnt  <= fill_nxt;
        valid_r   <= (fill_nxt == CNT_FULL);
        // Products above still read the old c_act; the swap lands for the next sample.
        if (commit_pend) begin
          for (int unsigned k = 0; k < N_TAPS; k++)
            c_act[k] <= c_shd[k];
        end
      end

      if (iEnSample && clip)
        sat_flag <= 1'b1;
      else if (iClrFlag)
        sat_flag <= 1'b0;

      // A request only arms when nothing is pending, so one landing in the swap cycle is dropped.
      if (iEnSample && commit_pend)
        commit_pend <= 1'b0;
      else if (iCoeffCommit)
        commit_pend <= 1'b1;
    end
  end

  assign oCascOut       = r_s[N_TAPS-1];
  assign oFirOut        = fir_out_r;
  assign oValid         = valid_r;
  assign oCommitPending = commit_pend;
  assign oSatFlag       = sat_flag;

endmodule
